// File: rtl/output_pipeline_pkg.sv
// Shared types and constants for the histogram-equalizer output stage.
package output_pipeline_pkg;

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_FETCH  = 4'd1,
        S_WAIT_W = 4'd2,
        S_LOOKUP = 4'd3,
        S_WAIT_C = 4'd4,
        S_DIVIDE = 4'd5,
        S_PACK   = 4'd6,
        S_WRITE  = 4'd7,
        S_DONE   = 4'd8
    } state_e;

    localparam int PIX_PER_WORD = 16;
    localparam int SCALE        = 255;
    localparam int CDF_W        = 20;

    // CDF entries live in a 256-entry bank selected by the top address bit.
    function automatic logic [15:0] cdf_addr(input logic bank, input logic [7:0] pix);
        return {bank, 7'b000_0000, pix};
    endfunction

endpackage

// File: rtl/output_pipeline_seq_divider.sv
// Restoring unsigned divider, one quotient bit per cycle; done pulses with the final quotient.
module seq_divider #(
    parameter int NUM_W = 28,
    parameter int DEN_W = 20
) (
    input  logic             clock,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic [NUM_W-1:0] numerator_i,
    input  logic [DEN_W-1:0] denominator_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [NUM_W-1:0] quotient_o
);

    localparam int CNT_W = $clog2(NUM_W + 1);

    logic [DEN_W-1:0] rem_q, rem_d;
    logic [NUM_W-1:0] quo_q, quo_d;
    logic [DEN_W-1:0] den_q, den_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [DEN_W:0]   trial_s;
    logic [DEN_W:0]   sub_s;
    logic             ge_s;

    // The numerator register shifts its MSB into the remainder while quotient bits fill from the LSB.
    always_comb begin
        trial_s = {rem_q, quo_q[NUM_W-1]};
        sub_s   = trial_s - {1'b0, den_q};
        ge_s    = (trial_s >= {1'b0, den_q});
    end

    // Next-state for the iteration registers.
    always_comb begin
        rem_d  = rem_q;
        quo_d  = quo_q;
        den_d  = den_q;
        cnt_d  = cnt_q;
        busy_d = busy_q;
        done_d = 1'b0;
        if (start_i) begin
            rem_d  = '0;
            quo_d  = numerator_i;
            den_d  = denominator_i;
            cnt_d  = '0;
            busy_d = 1'b1;
        end else if (busy_q) begin
            rem_d = ge_s ? sub_s[DEN_W-1:0] : trial_s[DEN_W-1:0];
            quo_d = {quo_q[NUM_W-2:0], ge_s};
            if (cnt_q == CNT_W'(NUM_W - 1)) begin
                busy_d = 1'b0;
                done_d = 1'b1;
                cnt_d  = '0;
            end else begin
                cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end else begin
            busy_d = 1'b0;
        end
    end

    // State registers.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            rem_q  <= '0;
            quo_q  <= '0;
            den_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            rem_q  <= rem_d;
            quo_q  <= quo_d;
            den_q  <= den_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end

    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign quotient_o = quo_q;

endmodule

// File: rtl/output_pipeline.sv
// Output stage: re-reads image words, maps each pixel through the equalization CDF, writes packed results.
module output_pipeline
    import output_pipeline_pkg::*;
#(
    parameter int          NUM_WORDS = 4,
    parameter logic [15:0] OUT_BASE  = 16'h0000,
    parameter int          DIV_W     = 28
) (
    input  logic             clock,
    input  logic             rst_n,
    input  logic             start,
    input  logic             cdf_valid,
    input  logic [19:0]      cdf_min,
    input  logic             cdfBaseOffset,
    input  logic [127:0]     m1ReadBus,
    input  logic [127:0]     m2ReadBus,
    output logic [15:0]      m1ReadAddr,
    output logic [15:0]      m2ReadAddr,
    output logic [15:0]      m4WriteAddr,
    output logic [127:0]     m4WriteBus,
    output logic             m4WE,
    output logic             done
);

    localparam logic [CDF_W-1:0] N_PIX     = CDF_W'(PIX_PER_WORD * NUM_WORDS);
    localparam logic [15:0]      LAST_WORD = 16'(NUM_WORDS - 1);

    state_e         state_q, state_d;
    logic [15:0]    word_q, word_d;
    logic [3:0]     idx_q, idx_d;
    logic [127:0]   pix_q, pix_d;
    logic [127:0]   out_q, out_d;
    logic [7:0]     res_q, res_d;
    logic [15:0]    m1a_q, m1a_d;
    logic [15:0]    m2a_q, m2a_d;
    logic [15:0]    m4a_q, m4a_d;
    logic [127:0]   m4bus_q, m4bus_d;
    logic           m4we_q, m4we_d;
    logic           done_q, done_d;

    logic [CDF_W-1:0] cdf_s, diff_s, den_s;
    logic [DIV_W-1:0] num_s, div_quo_s;
    logic             div_start_s, div_busy_s, div_done_s;
    logic [3:0]       idx_next_s;
    logic             unused_bits_s;

    function automatic logic [7:0] sat_u8(input logic [DIV_W-1:0] q);
        if (q > DIV_W'(SCALE)) begin
            return 8'hFF;
        end else begin
            return q[7:0];
        end
    endfunction

    // Rounded-division operands; absent pixels (cdf below cdf_min) collapse to a zero numerator term.
    always_comb begin
        cdf_s  = m2ReadBus[CDF_W-1:0];
        diff_s = (cdf_s >= cdf_min) ? (cdf_s - cdf_min) : {CDF_W{1'b0}};
        den_s  = N_PIX - cdf_min;
        num_s  = ({{(DIV_W-CDF_W){1'b0}}, diff_s} * DIV_W'(SCALE))
               + {{(DIV_W-CDF_W+1){1'b0}}, den_s[CDF_W-1:1]};
    end

    assign idx_next_s    = idx_q + 4'd1;
    assign unused_bits_s = ^{m2ReadBus[127:CDF_W], div_busy_s};

    seq_divider #(
        .NUM_W (DIV_W),
        .DEN_W (CDF_W)
    ) u_div (
        .clock         (clock),
        .rst_n         (rst_n),
        .start_i       (div_start_s),
        .numerator_i   (num_s),
        .denominator_i (den_s),
        .busy_o        (div_busy_s),
        .done_o        (div_done_s),
        .quotient_o    (div_quo_s)
    );

    // Sequencer next-state; addresses are set on entry so they are stable for the whole read cycle.
    always_comb begin
        state_d     = state_q;
        word_d      = word_q;
        idx_d       = idx_q;
        pix_d       = pix_q;
        out_d       = out_q;
        res_d       = res_q;
        m1a_d       = m1a_q;
        m2a_d       = m2a_q;
        m4a_d       = m4a_q;
        m4bus_d     = m4bus_q;
        m4we_d      = 1'b0;
        done_d      = 1'b0;
        div_start_s = 1'b0;
        if ((state_q != S_IDLE) && !start) begin
            state_d = S_IDLE;
            word_d  = 16'd0;
            idx_d   = 4'd0;
            m1a_d   = 16'd0;
            m2a_d   = 16'd0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start && cdf_valid) begin
                        state_d = S_FETCH;
                        m1a_d   = word_q;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                S_FETCH: begin
                    state_d = S_WAIT_W;
                end
                S_WAIT_W: begin
                    pix_d   = m1ReadBus;
                    idx_d   = 4'd0;
                    m2a_d   = cdf_addr(cdfBaseOffset, m1ReadBus[7:0]);
                    state_d = S_LOOKUP;
                end
                S_LOOKUP: begin
                    state_d = S_WAIT_C;
                end
                S_WAIT_C: begin
                    if (den_s == {CDF_W{1'b0}}) begin
                        res_d   = 8'h00;
                        state_d = S_PACK;
                    end else begin
                        div_start_s = 1'b1;
                        state_d     = S_DIVIDE;
                    end
                end
                S_DIVIDE: begin
                    if (div_done_s) begin
                        res_d   = sat_u8(div_quo_s);
                        state_d = S_PACK;
                    end else begin
                        state_d = S_DIVIDE;
                    end
                end
                S_PACK: begin
                    out_d[{idx_q, 3'b000} +: 8] = res_q;
                    if (idx_q == 4'd15) begin
                        m4we_d  = 1'b1;
                        m4a_d   = OUT_BASE + word_q;
                        m4bus_d = out_d;
                        idx_d   = 4'd0;
                        state_d = S_WRITE;
                    end else begin
                        idx_d   = idx_next_s;
                        m2a_d   = cdf_addr(cdfBaseOffset, pix_q[{idx_next_s, 3'b000} +: 8]);
                        state_d = S_LOOKUP;
                    end
                end
                S_WRITE: begin
                    if (word_q == LAST_WORD) begin
                        done_d  = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        word_d  = word_q + 16'd1;
                        m1a_d   = word_q + 16'd1;
                        state_d = S_FETCH;
                    end
                end
                S_DONE: begin
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // Sequencer and output registers.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            word_q  <= 16'd0;
            idx_q   <= 4'd0;
            pix_q   <= 128'd0;
            out_q   <= 128'd0;
            res_q   <= 8'd0;
            m1a_q   <= 16'd0;
            m2a_q   <= 16'd0;
            m4a_q   <= 16'd0;
            m4bus_q <= 128'd0;
            m4we_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            idx_q   <= idx_d;
            pix_q   <= pix_d;
            out_q   <= out_d;
            res_q   <= res_d;
            m1a_q   <= m1a_d;
            m2a_q   <= m2a_d;
            m4a_q   <= m4a_d;
            m4bus_q <= m4bus_d;
            m4we_q  <= m4we_d;
            done_q  <= done_d;
        end
    end

    assign m1ReadAddr  = m1a_q;
    assign m2ReadAddr  = m2a_q;
    assign m4WriteAddr = m4a_q;
    assign m4WriteBus  = m4bus_q;
    assign m4WE        = m4we_q;
    assign done        = done_q;

endmodule

// File: tb/tb_output_pipeline.sv
// Directed bench for output_pipeline with behavioural m1/m2/m4 memories.
module tb_output_pipeline;

    logic         clock = 1'b0;
    logic         rst_n;
    logic         start;
    logic         cdf_valid;
    logic [19:0]  cdf_min;
    logic         cdfBaseOffset;
    logic [127:0] m1ReadBus;
    logic [127:0] m2ReadBus;
    logic [15:0]  m1ReadAddr;
    logic [15:0]  m2ReadAddr;
    logic [15:0]  m4WriteAddr;
    logic [127:0] m4WriteBus;
    logic         m4WE;
    logic         done;

    int vec_cnt = 0;
    int err_cnt = 0;

    logic [127:0] m1_mem [0:3];
    logic [19:0]  m2_mem [0:1][0:255];
    logic [127:0] m4_mem [0:3];
    int           m4_wr  [0:3];
    int           wr_total;
    int           bad_addr;
    logic [15:0]  first_wr_addr;
    logic         first_seen;
    logic         m4_clr;

    always #5 clock = ~clock;

    output_pipeline dut (
        .clock         (clock),
        .rst_n         (rst_n),
        .start         (start),
        .cdf_valid     (cdf_valid),
        .cdf_min       (cdf_min),
        .cdfBaseOffset (cdfBaseOffset),
        .m1ReadBus     (m1ReadBus),
        .m2ReadBus     (m2ReadBus),
        .m1ReadAddr    (m1ReadAddr),
        .m2ReadAddr    (m2ReadAddr),
        .m4WriteAddr   (m4WriteAddr),
        .m4WriteBus    (m4WriteBus),
        .m4WE          (m4WE),
        .done          (done)
    );

    // Synchronous memories: read data appears the cycle after the address.
    always @(posedge clock) begin
        m1ReadBus <= m1_mem[m1ReadAddr[1:0]];
        m2ReadBus <= {108'd0, m2_mem[m2ReadAddr[15]][m2ReadAddr[7:0]]};
        if (m4_clr) begin
            for (int i = 0; i < 4; i++) begin
                m4_mem[i] <= {16{8'hAA}};
                m4_wr[i]  <= 0;
            end
            wr_total   <= 0;
            bad_addr   <= 0;
            first_seen <= 1'b0;
        end else if (m4WE === 1'b1) begin
            wr_total <= wr_total + 1;
            if (!first_seen) begin
                first_seen    <= 1'b1;
                first_wr_addr <= m4WriteAddr;
            end
            if (m4WriteAddr < 16'd4) begin
                m4_mem[m4WriteAddr[1:0]] <= m4WriteBus;
                m4_wr[m4WriteAddr[1:0]]  <= m4_wr[m4WriteAddr[1:0]] + 1;
            end else begin
                bad_addr <= bad_addr + 1;
            end
        end
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vec_cnt++;
        assert (obs === exp) else begin
            err_cnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_m4();
        m4_clr = 1'b1;
        @(negedge clock);
        m4_clr = 1'b0;
        @(negedge clock);
    endtask

    task automatic wait_done(input string tag, input int max_cyc);
        int n = 0;
        while (done !== 1'b1 && n < max_cyc) begin
            @(negedge clock);
            n++;
        end
        chk({tag, "_done"}, 128'(done), 128'd1);
        chk({tag, "_writes_at_done"}, 128'(wr_total), 128'd4);
        chk({tag, "_bad_addr"}, 128'(bad_addr), 128'd0);
    endtask

    task automatic wait_wr(input logic [15:0] addr, input int max_cyc);
        int n = 0;
        while (!(m4WE === 1'b1 && m4WriteAddr === addr) && n < max_cyc) begin
            @(negedge clock);
            n++;
        end
        chk("wait_write", 128'(m4WE === 1'b1 && m4WriteAddr === addr), 128'd1);
    endtask

    task automatic load_ramp();
        for (int w = 0; w < 4; w++)
            for (int b = 0; b < 16; b++)
                m1_mem[w][8*b +: 8] = 8'(16 * w + b);
        for (int k = 0; k < 2; k++)
            for (int v = 0; v < 256; v++)
                m2_mem[k][v] = (v < 64) ? 20'(v + 1) : 20'd64;
        cdf_min = 20'd1;
    endtask

    task automatic check_ramp(input string tag);
        chk({tag, "_h0"},     128'(m4_mem[0][7:0]),     128'd0);
        chk({tag, "_h1"},     128'(m4_mem[0][15:8]),    128'd4);
        chk({tag, "_h2"},     128'(m4_mem[0][23:16]),   128'd8);
        chk({tag, "_h15"},    128'(m4_mem[0][127:120]), 128'd61);
        chk({tag, "_h16"},    128'(m4_mem[1][7:0]),     128'd65);
        chk({tag, "_h32"},    128'(m4_mem[2][7:0]),     128'd130);
        chk({tag, "_h48"},    128'(m4_mem[3][7:0]),     128'd194);
        chk({tag, "_h63"},    128'(m4_mem[3][127:120]), 128'd255);
        for (int i = 0; i < 4; i++)
            chk({tag, "_wr_once"}, 128'(m4_wr[i]), 128'd1);
    endtask

    initial begin
        rst_n         = 1'b0;
        start         = 1'b0;
        cdf_valid     = 1'b0;
        cdf_min       = 20'd0;
        cdfBaseOffset = 1'b0;
        m4_clr        = 1'b0;
        load_ramp();
        repeat (3) @(negedge clock);

        // Reset values.
        chk("rst_m1addr", 128'(m1ReadAddr), 128'd0);
        chk("rst_m2addr", 128'(m2ReadAddr), 128'd0);
        chk("rst_m4addr", 128'(m4WriteAddr), 128'd0);
        chk("rst_m4bus",  m4WriteBus, 128'd0);
        chk("rst_m4we",   128'(m4WE), 128'd0);
        chk("rst_done",   128'(done), 128'd0);
        rst_n = 1'b1;
        clear_m4();

        // start without cdf_valid: no reads, then FETCH the cycle after cdf_valid rises; bank 1.
        cdfBaseOffset = 1'b1;
        start         = 1'b1;
        repeat (6) @(negedge clock);
        chk("idle_m2addr", 128'(m2ReadAddr), 128'd0);
        chk("idle_writes", 128'(wr_total), 128'd0);
        chk("idle_done",   128'(done), 128'd0);
        cdf_valid = 1'b1;
        @(negedge clock);
        @(negedge clock);
        chk("fetch_wait_m2addr", 128'(m2ReadAddr), 128'd0);
        @(negedge clock);
        chk("lookup_m2addr", 128'(m2ReadAddr), 128'h8000);
        cdf_valid = 1'b0;
        wait_done("ramp_bank1", 5000);
        check_ramp("ramp_bank1");
        start = 1'b0;
        repeat (2) @(negedge clock);
        chk("done_release", 128'(done), 128'd0);

        // Flat image: den = 0, every output byte zero.
        cdfBaseOffset = 1'b0;
        for (int w = 0; w < 4; w++) m1_mem[w] = {16{8'h10}};
        for (int v = 0; v < 256; v++) m2_mem[0][v] = (v < 16) ? 20'd0 : 20'd64;
        cdf_min = 20'd64;
        clear_m4();
        cdf_valid = 1'b1;
        start     = 1'b1;
        wait_done("flat", 5000);
        for (int i = 0; i < 4; i++) begin
            chk("flat_word", m4_mem[i], 128'd0);
            chk("flat_wr_once", 128'(m4_wr[i]), 128'd1);
        end
        start = 1'b0;
        repeat (2) @(negedge clock);

        // Alternating 0x00 / 0xFF words.
        for (int w = 0; w < 4; w++) m1_mem[w] = (w % 2 == 1) ? {16{8'hFF}} : 128'd0;
        for (int v = 0; v < 256; v++) m2_mem[0][v] = (v == 255) ? 20'd64 : 20'd32;
        cdf_min = 20'd32;
        clear_m4();
        start = 1'b1;
        wait_done("bw", 5000);
        chk("bw_w0", m4_mem[0], 128'd0);
        chk("bw_w1", m4_mem[1], {16{8'hFF}});
        chk("bw_w2", m4_mem[2], 128'd0);
        chk("bw_w3", m4_mem[3], {16{8'hFF}});
        start = 1'b0;
        repeat (2) @(negedge clock);

        // Abort during word 2 LOOKUP, then restart from OUT_BASE.
        load_ramp();
        clear_m4();
        start = 1'b1;
        wait_wr(16'd1, 3000);
        repeat (3) @(negedge clock);
        start = 1'b0;
        repeat (1200) @(negedge clock);
        chk("abort_no_w2",    128'(m4_wr[2]), 128'd0);
        chk("abort_writes",   128'(wr_total), 128'd2);
        chk("abort_m1addr",   128'(m1ReadAddr), 128'd0);
        chk("abort_done",     128'(done), 128'd0);
        clear_m4();
        start = 1'b1;
        wait_done("restart", 5000);
        chk("restart_first_addr", 128'(first_wr_addr), 128'd0);
        check_ramp("restart");
        start = 1'b0;
        repeat (2) @(negedge clock);

        // rst_n during a DIVIDE of word 1.
        clear_m4();
        start = 1'b1;
        wait_wr(16'd0, 3000);
        repeat (8) @(negedge clock);
        chk("pre_rst_m1addr", 128'(m1ReadAddr), 128'd1);
        chk("pre_rst_m2addr", 128'(m2ReadAddr), 128'h0010);
        rst_n = 1'b0;
        #1;
        chk("midrst_m1addr", 128'(m1ReadAddr), 128'd0);
        chk("midrst_m2addr", 128'(m2ReadAddr), 128'd0);
        chk("midrst_m4addr", 128'(m4WriteAddr), 128'd0);
        chk("midrst_m4bus",  m4WriteBus, 128'd0);
        chk("midrst_m4we",   128'(m4WE), 128'd0);
        chk("midrst_done",   128'(done), 128'd0);
        start = 1'b0;
        @(negedge clock);
        rst_n = 1'b1;
        clear_m4();
        start = 1'b1;
        wait_done("post_rst", 5000);
        check_ramp("post_rst");
        start = 1'b0;
        repeat (2) @(negedge clock);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
